// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI serdes between NUM_REQ requesters; start one cycle after req in IDLE, ack one cycle after done.
// Requesters hold req until ack; a serdes that never signals done is aborted by the watchdog with err.
module spi_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TX_WIDTH       = 16,
    parameter int RX_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        spi_clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*TX_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        err,
    output logic [RX_WIDTH-1:0]         rdata,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy,
    output logic                        serdes_start,
    output logic [TX_WIDTH-1:0]         serdes_data_tx,
    input  logic                        serdes_done,
    input  logic [RX_WIDTH-1:0]         serdes_data_rx
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [PW-1:0] IDX_LAST = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0]    grant_d, ack_d;
    logic                  err_d, start_d, busy_d;
    logic [RX_WIDTH-1:0]   rdata_d;
    logic [TX_WIDTH-1:0]   tx_d;
    logic [TX_WIDTH-1:0]   slot [NUM_REQ];
    logic                  win_vld;
    logic [PW-1:0]         win_idx;
    logic [PW-1:0]         cand;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slot[i] = req_data[i*TX_WIDTH +: TX_WIDTH];
        end
    end

    // Scan downward so the last hit is the nearest set bit at or above the pointer.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant;
        tx_d    = serdes_data_tx;
        start_d = serdes_start;
        rdata_d = rdata;
        ack_d   = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = XFER;
                    grant_d = NUM_REQ'(1) << win_idx;
                    tx_d    = slot[win_idx];
                    start_d = 1'b1;
                    ptr_d   = (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
                    cnt_d   = '0;
                end
            end
            XFER: begin
                if (serdes_done) begin
                    state_d = RELEASE;
                    rdata_d = serdes_data_rx;
                    ack_d   = grant;
                    start_d = 1'b0;
                end else if (TIMEOUT_CYCLES > 0 && cnt_q == CNT_LAST) begin
                    state_d = RELEASE;
                    ack_d   = grant;
                    err_d   = 1'b1;
                    start_d = 1'b0;
                end else if (TIMEOUT_CYCLES > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                // A level-style done must fall before the next grant can start.
                if (!serdes_done) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge spi_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            cnt_q          <= '0;
            grant          <= '0;
            ack            <= '0;
            err            <= 1'b0;
            rdata          <= '0;
            busy           <= 1'b0;
            serdes_start   <= 1'b0;
            serdes_data_tx <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            grant          <= grant_d;
            ack            <= ack_d;
            err            <= err_d;
            rdata          <= rdata_d;
            busy           <= busy_d;
            serdes_start   <= start_d;
            serdes_data_tx <= tx_d;
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: directed scenarios plus randomized round-robin traffic against a transaction-level model.
module tb_spi_arbiter;

    logic        spi_clk = 1'b0;
    logic        reset_n;
    logic [2:0]  req;
    logic [47:0] req_data;
    logic        serdes_done;
    logic [7:0]  serdes_data_rx;
    logic [2:0]  ack, grant;
    logic        err, busy, serdes_start;
    logic [7:0]  rdata;
    logic [15:0] serdes_data_tx;

    logic [2:0]  t_req;
    logic [47:0] t_req_data;
    logic        t_done;
    logic [7:0]  t_rx;
    logic [2:0]  t_ack, t_grant;
    logic        t_err, t_busy, t_start;
    logic [7:0]  t_rdata;
    logic [15:0] t_tx;

    int          checks = 0;
    int          failures = 0;
    int          mptr;
    int          win;
    int          w;
    logic [2:0]  next_req;
    logic [47:0] next_data;
    int          ack_cnt [3];

    spi_arbiter #(.NUM_REQ(3), .TX_WIDTH(16), .RX_WIDTH(8), .TIMEOUT_CYCLES(1024)) dut (
        .spi_clk(spi_clk), .reset_n(reset_n), .req(req), .req_data(req_data),
        .ack(ack), .err(err), .rdata(rdata), .grant(grant), .busy(busy),
        .serdes_start(serdes_start), .serdes_data_tx(serdes_data_tx),
        .serdes_done(serdes_done), .serdes_data_rx(serdes_data_rx)
    );

    spi_arbiter #(.NUM_REQ(3), .TX_WIDTH(16), .RX_WIDTH(8), .TIMEOUT_CYCLES(16)) dut_to (
        .spi_clk(spi_clk), .reset_n(reset_n), .req(t_req), .req_data(t_req_data),
        .ack(t_ack), .err(t_err), .rdata(t_rdata), .grant(t_grant), .busy(t_busy),
        .serdes_start(t_start), .serdes_data_tx(t_tx),
        .serdes_done(t_done), .serdes_data_rx(t_rx)
    );

    always #5 spi_clk = ~spi_clk;

    task automatic tick();
        @(posedge spi_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] onehot(input int i);
        return 3'(1 << i);
    endfunction

    // Reference rule: first requesting index at or after the pointer, wrapping.
    function automatic int pick(input logic [2:0] rv, input int p);
        int idx;
        for (int k = 0; k < 3; k++) begin
            idx = (p + k) % 3;
            if (rv[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [15:0] slice(input logic [47:0] d, input int i);
        logic [47:0] s;
        s = d >> (i * 16);
        return s[15:0];
    endfunction

    task automatic count_acks();
        ack_cnt[0] += int'(ack[0]);
        ack_cnt[1] += int'(ack[1]);
        ack_cnt[2] += int'(ack[2]);
    endtask

    task automatic serve(input string tag, input int exp_w, input int exp_wait,
                         input int delay, input logic [7:0] rx, input int done_len);
        logic [15:0] exp_tx;
        int          n;
        exp_tx = slice(req_data, exp_w);
        n = 0;
        do begin
            tick();
            n++;
        end while (serdes_start !== 1'b1 && n < 64);
        chk({tag, "_start_seen"}, serdes_start, 1'b1);
        if (exp_wait > 0) chk({tag, "_start_latency"}, n, exp_wait);
        chk({tag, "_grant"}, grant, onehot(exp_w));
        chk({tag, "_tx"}, serdes_data_tx, exp_tx);
        chk({tag, "_busy"}, busy, 1'b1);
        mptr = (exp_w + 1) % 3;
        repeat (delay - 1) tick();
        chk({tag, "_start_held"}, {serdes_start, serdes_data_tx}, {1'b1, exp_tx});
        serdes_done    = 1'b1;
        serdes_data_rx = rx;
        tick();
        count_acks();
        chk({tag, "_ack"}, ack, onehot(exp_w));
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_rdata"}, rdata, rx);
        chk({tag, "_start_drop"}, serdes_start, 1'b0);
        req      = next_req;
        req_data = next_data;
        repeat (done_len - 1) begin
            tick();
            count_acks();
            chk({tag, "_level_hold"}, {ack, busy, serdes_start}, {3'b000, 1'b1, 1'b0});
        end
        serdes_done    = 1'b0;
        serdes_data_rx = 8'($urandom());
    endtask

    initial begin
        reset_n = 1'b1;
        req = '0; req_data = '0; serdes_done = 1'b0; serdes_data_rx = '0;
        t_req = '0; t_req_data = '0; t_done = 1'b0; t_rx = '0;
        next_req = '0; next_data = '0; mptr = 0;
        ack_cnt[0] = 0; ack_cnt[1] = 0; ack_cnt[2] = 0;
        #2 reset_n = 1'b0;
        #1;
        chk("reset_outputs", {ack, err, rdata, grant, busy, serdes_start, serdes_data_tx}, '0);
        chk("reset_outputs_to", {t_ack, t_err, t_rdata, t_grant, t_busy, t_start, t_tx}, '0);
        tick();
        tick();
        #3 reset_n = 1'b1;
        tick();

        // Single requester 1, done 18 cycles after start.
        req = 3'b010;
        req_data = {16'h0000, 16'h2D08, 16'h0000};
        next_req = 3'b000;
        next_data = req_data;
        serve("t1", 1, 1, 18, 8'hA5, 1);

        // Reset in the middle of a transfer.
        req = 3'b010;
        req_data = {16'h0000, 16'h1111, 16'h0000};
        w = 0;
        do begin
            tick();
            w++;
        end while (serdes_start !== 1'b1 && w < 64);
        chk("rst_pre_start", serdes_start, 1'b1);
        chk("rst_pre_grant", grant, 3'b010);
        repeat (3) tick();
        reset_n = 1'b0;
        #2;
        chk("rst_async", {serdes_start, grant, busy, ack, rdata}, '0);
        req = 3'b101;
        req_data = 48'hC0DE_BEEF_1357;
        mptr = 0;
        #3 reset_n = 1'b1;

        // 3'b101 after reset: 0 then 2, then all three for 9 round-robin turns.
        next_req = 3'b100;
        next_data = req_data;
        serve("rr101_a", 0, 1, 3, 8'h11, 1);
        next_req = 3'b111;
        serve("rr101_b", 2, 2, 5, 8'h22, 1);
        ack_cnt[0] = 0; ack_cnt[1] = 0; ack_cnt[2] = 0;
        for (int i = 0; i < 9; i++) begin
            next_req = (i == 8) ? 3'b000 : 3'b111;
            serve("rr_all", i % 3, 2, int'($urandom_range(1, 6)), 8'($urandom()), 1);
        end
        chk("rr_cnt0", ack_cnt[0], 3);
        chk("rr_cnt1", ack_cnt[1], 3);
        chk("rr_cnt2", ack_cnt[2], 3);

        // Level-style done held 5 cycles.
        req = 3'b100;
        next_req = 3'b000;
        ack_cnt[0] = 0; ack_cnt[1] = 0; ack_cnt[2] = 0;
        serve("lvl", 2, 2, 4, 8'h77, 5);
        tick();
        chk("lvl_idle", {busy, grant, serdes_start}, '0);
        chk("lvl_one_ack", ack_cnt[2], 1);

        // Randomized traffic checked against the pointer model.
        req = 3'($urandom_range(1, 7));
        req_data = 48'({$urandom(), $urandom()});
        for (int i = 0; i < 20; i++) begin
            win = pick(req, mptr);
            next_req = (i == 19) ? 3'b000 : 3'($urandom_range(1, 7));
            next_data = 48'({$urandom(), $urandom()});
            serve("rnd", win, (i == 0) ? 1 : 2, int'($urandom_range(1, 12)),
                  8'($urandom()), int'($urandom_range(1, 3)));
        end

        // Watchdog instance: a good transfer, a timeout, then recovery.
        t_req = 3'b001;
        t_req_data = {16'h0000, 16'h0000, 16'h1111};
        w = 0;
        do begin
            tick();
            w++;
        end while (t_start !== 1'b1 && w < 64);
        chk("to_first_start", {t_start, t_tx}, {1'b1, 16'h1111});
        repeat (2) tick();
        t_done = 1'b1;
        t_rx = 8'h3C;
        tick();
        chk("to_first_ack", {t_ack, t_err, t_rdata}, {3'b001, 1'b0, 8'h3C});
        t_req = 3'b100;
        t_req_data = {16'hBEEF, 16'h0000, 16'h0000};
        t_done = 1'b0;
        t_rx = 8'hEE;
        w = 0;
        do begin
            tick();
            w++;
        end while (t_start !== 1'b1 && w < 64);
        chk("to_start", {t_start, t_grant, t_tx}, {1'b1, 3'b100, 16'hBEEF});
        w = 0;
        do begin
            tick();
            w++;
        end while (t_start === 1'b1 && w < 40);
        chk("to_xfer_cycles", w, 16);
        chk("to_abort", {t_ack, t_err, t_rdata, t_grant}, {3'b100, 1'b1, 8'h3C, 3'b100});
        t_req = 3'b000;
        tick();
        chk("to_err_pulse", {t_ack, t_err, t_busy}, '0);
        t_req = 3'b010;
        t_req_data = {16'h0000, 16'h1234, 16'h0000};
        w = 0;
        do begin
            tick();
            w++;
        end while (t_start !== 1'b1 && w < 64);
        chk("to_recover_start", {t_start, t_grant, t_tx}, {1'b1, 3'b010, 16'h1234});
        repeat (2) tick();
        t_done = 1'b1;
        t_rx = 8'h5A;
        tick();
        chk("to_recover_ack", {t_ack, t_err, t_rdata}, {3'b010, 1'b0, 8'h5A});
        t_req = 3'b000;
        t_done = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
